// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the traffic phase scheduler: light codes,
// phase state encoding and a width helper.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } phase_state_t;

  // Index width for n items, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N_APPR.
module rr_pick
  import traffic_pkg::*;
#(
  parameter int N_APPR = 4,
  parameter int IDX_W  = clog2(N_APPR)
) (
  input  logic [N_APPR-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic [2*N_APPR-1:0] req_dbl;
  logic [N_APPR-1:0]   req_rot;
  logic [IDX_W:0]      sum;

  always_comb begin
    req_dbl = {req, req};
    req_rot = N_APPR'(req_dbl >> ptr);
    valid   = |req_rot;
    idx     = '0;
    sum     = '0;
    // Scan downwards so the lowest rotated position wins.
    for (int i = N_APPR - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(N_APPR)) sum = sum - (IDX_W+1)'(N_APPR);
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection sequencer: shares one green phase among N_APPR approaches
// through timed GREEN -> YELLOW -> ALLRED phases with round-robin grants.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4,
  localparam int IDX_W    = clog2(N_APPR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPR-1:0]     sense,
  input  logic                  hold,
  output logic [2*N_APPR-1:0]   light,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  phase_done
);

  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_RED  = CNT_W'(ALLRED_T - 1);

  phase_state_t      state;
  logic [CNT_W-1:0]  timer;
  logic [IDX_W-1:0]  ptr;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_APPR-1:0] others;
  logic              green_exit;

  function automatic logic [2*N_APPR-1:0] light_at(input logic [IDX_W-1:0] idx,
                                                   input logic [1:0]       code);
    return (2*N_APPR)'(code) << (2 * int'(idx));
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_APPR - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(
    .N_APPR (N_APPR),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req   (sense),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Green ends only when someone else waits and either the owner has left
  // or the maximum green has been served.
  always_comb begin
    others             = sense;
    others[active_idx] = 1'b0;
    green_exit = (timer >= T_GMIN) && (|others) &&
                 (!sense[active_idx] || (timer == T_GMAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      ptr        <= '0;
      active_idx <= '0;
      phase_done <= 1'b0;
      light      <= '0;
    end else begin
      phase_done <= 1'b0;
      if (!hold) begin
        case (state)
          ST_IDLE: begin
            if (pick_valid) begin
              state      <= ST_GREEN;
              timer      <= '0;
              active_idx <= pick_idx;
              ptr        <= next_ptr(pick_idx);
              light      <= light_at(pick_idx, LIGHT_GREEN);
            end
          end
          ST_GREEN: begin
            if (green_exit) begin
              state <= ST_YELLOW;
              timer <= '0;
              light <= light_at(active_idx, LIGHT_YELLOW);
            end else if (timer != T_GMAX) begin
              timer <= timer + 1'b1;
            end
          end
          ST_YELLOW: begin
            if (timer == T_YEL) begin
              state      <= ST_ALLRED;
              timer      <= '0;
              light      <= '0;
              phase_done <= (ALLRED_T == 1);
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_ALLRED: begin
            // phase_done is raised so that it coincides with the final red cycle.
            if (timer == T_RED) begin
              timer <= '0;
              if (pick_valid) begin
                state      <= ST_GREEN;
                active_idx <= pick_idx;
                ptr        <= next_ptr(pick_idx);
                light      <= light_at(pick_idx, LIGHT_GREEN);
              end else begin
                state <= ST_IDLE;
                light <= '0;
              end
            end else begin
              timer      <= timer + 1'b1;
              phase_done <= (timer + 1'b1 == T_RED);
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
            light <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus
// randomized traffic against a phase-length reference model.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YT   = 2;
  localparam int AT   = 1;
  localparam int IW   = traffic_pkg::clog2(N);

  localparam int P_IDLE   = 0;
  localparam int P_GREEN  = 1;
  localparam int P_YELLOW = 2;
  localparam int P_ALLRED = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   sense;
  logic           hold;
  logic [2*N-1:0] light;
  logic [IW-1:0]  active_idx;
  logic           phase_done;

  traffic_phase_scheduler #(
    .N_APPR    (N),
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense      (sense),
    .hold       (hold),
    .light      (light),
    .active_idx (active_idx),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pd_seen  = 0;

  // Reference model: which phase we are in, how many un-held cycles of it
  // have already elapsed, who holds the right of way, and where the
  // round-robin search starts next time.
  int m_phase, m_elapsed, m_active, m_next;
  bit m_pd;

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_active = 0; m_next = 0; m_pd = 0;
  endtask

  function automatic int first_waiting(input logic [N-1:0] s, input int start);
    for (int j = 0; j < N; j++)
      if (s[(start + j) % N]) return (start + j) % N;
    return -1;
  endfunction

  task automatic model_grant_or_idle(input logic [N-1:0] s);
    int w;
    w = first_waiting(s, m_next);
    m_elapsed = 0;
    if (w >= 0) begin
      m_phase = P_GREEN; m_active = w; m_next = (w + 1) % N;
    end else begin
      m_phase = P_IDLE;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] s, input bit h);
    int this_len;
    logic [N-1:0] rest;
    m_pd = 0;
    if (h) return;
    this_len = m_elapsed + 1;
    rest = s;
    rest[m_active] = 1'b0;
    case (m_phase)
      P_IDLE:   if (s != '0) model_grant_or_idle(s);
      P_GREEN:  if (this_len >= GMIN && rest != '0 && (!s[m_active] || this_len >= GMAX)) begin
                  m_phase = P_YELLOW; m_elapsed = 0;
                end else m_elapsed = this_len;
      P_YELLOW: if (this_len == YT) begin m_phase = P_ALLRED; m_elapsed = 0; end
                else m_elapsed = this_len;
      default:  if (this_len == AT) model_grant_or_idle(s);
                else m_elapsed = this_len;
    endcase
    m_pd = (m_phase == P_ALLRED) && (m_elapsed == AT - 1);
  endtask

  function automatic logic [2*N-1:0] exp_light();
    logic [2*N-1:0] v;
    v = '0;
    if (m_phase == P_GREEN)  v = (2*N)'(2'b10) << (2 * m_active);
    if (m_phase == P_YELLOW) v = (2*N)'(2'b01) << (2 * m_active);
    return v;
  endfunction

  task automatic cyc();
    model_edge(sense, hold);
    @(posedge clk);
    #1;
    if (phase_done) pd_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    pd_seen = 0;
  endtask

  task automatic count_run(input logic [2*N-1:0] code, output int n);
    n = 0;
    for (int i = 0; i < 64 && light == code; i++) begin
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; sense = 4'b0001;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (light !== 8'h00 || active_idx !== 2'd0 || phase_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: light=%h idx=%0d pd=%b, want light=00 idx=0 pd=0", light, active_idx, phase_done);
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if (light !== 8'h02 || active_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL first_grant: light=%h idx=%0d, want light=02 idx=0", light, active_idx);
    end
  endtask

  task automatic test_lone_requester();
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (light !== 8'h02 || phase_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lone_rest: %0d cycles left green-02 or pulsed phase_done, want 0", bad);
    end
  endtask

  task automatic test_max_green();
    int g, y, r;
    do_reset();
    sense = 4'b0001;
    cyc();
    sense = 4'b0101;
    count_run(8'h02, g);
    count_run(8'h01, y);
    count_run(8'h00, r);
    n_checks++;
    if (g != GMAX || y != YT || r != AT || pd_seen != 1) begin
      n_fail++;
      $display("FAIL max_green_seq: green=%0d yellow=%0d red=%0d pd=%0d, want %0d %0d %0d 1", g, y, r, pd_seen, GMAX, YT, AT);
    end
    n_checks++;
    if (light !== 8'h20 || active_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL max_green_next: light=%h idx=%0d, want light=20 idx=2", light, active_idx);
    end
  endtask

  task automatic test_min_green();
    int g, y, r;
    do_reset();
    sense = 4'b0001;
    cyc();
    sense = 4'b0101;
    cyc();
    sense = 4'b0100;
    count_run(8'h02, g);
    g = g + 1;
    count_run(8'h01, y);
    count_run(8'h00, r);
    n_checks++;
    if (g != GMIN || y != YT || r != AT || pd_seen != 1) begin
      n_fail++;
      $display("FAIL min_green_seq: green=%0d yellow=%0d red=%0d pd=%0d, want %0d %0d %0d 1", g, y, r, pd_seen, GMIN, YT, AT);
    end
    n_checks++;
    if (light !== 8'h20 || active_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL min_green_next: light=%h idx=%0d, want light=20 idx=2", light, active_idx);
    end
  endtask

  task automatic test_round_robin();
    int g, y, r;
    logic [7:0] gc, yc;
    do_reset();
    sense = 4'b1111;
    cyc();
    for (int k = 0; k < 4; k++) begin
      gc = 8'h02 << (2 * k);
      yc = 8'h01 << (2 * k);
      n_checks++;
      if (active_idx !== IW'(k) || light !== gc) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: light=%h idx=%0d, want light=%h idx=%0d", k, light, active_idx, gc, k);
      end
      count_run(gc, g);
      count_run(yc, y);
      count_run(8'h00, r);
      n_checks++;
      if (g != GMAX || y != YT || r != AT) begin
        n_fail++;
        $display("FAIL rr_phase_%0d: green=%0d yellow=%0d red=%0d, want %0d %0d %0d", k, g, y, r, GMAX, YT, AT);
      end
    end
    n_checks++;
    if (active_idx !== 2'd0 || light !== 8'h02 || pd_seen != 4) begin
      n_fail++;
      $display("FAIL rr_wrap: light=%h idx=%0d pd=%0d, want light=02 idx=0 pd=4", light, active_idx, pd_seen);
    end
  endtask

  task automatic test_hold_and_async_reset();
    int g, y, r, bad;
    do_reset();
    sense = 4'b0001;
    cyc();
    sense = 4'b0010;
    count_run(8'h02, g);
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (light !== 8'h01 || phase_done !== 1'b0) bad++;
    end
    hold = 1'b0;
    n_checks++;
    if (bad != 0 || g != GMIN) begin
      n_fail++;
      $display("FAIL hold_freeze: %0d unfrozen cycles, green=%0d, want 0 and %0d", bad, g, GMIN);
    end
    count_run(8'h01, y);
    count_run(8'h00, r);
    n_checks++;
    if (y != YT || r != AT || light !== 8'h08 || active_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_release: yellow=%0d red=%0d light=%h idx=%0d, want %0d %0d 08 1", y, r, light, active_idx, YT, AT);
    end
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (light !== 8'h00 || active_idx !== 2'd0 || phase_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: light=%h idx=%0d pd=%b, want 00 0 0", light, active_idx, phase_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sense = 4'b0000;
    cyc();
    cyc();
    n_checks++;
    if (light !== 8'h00 || phase_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: light=%h pd=%b, want 00 0", light, phase_done);
    end
  endtask

  task automatic test_random_traffic();
    do_reset();
    sense = '0;
    hold  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) sense = N'($urandom_range(0, (1 << N) - 1));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
      n_checks++;
      if (light !== exp_light() || active_idx !== IW'(m_active) || phase_done !== m_pd) begin
        n_fail++;
        $display("FAIL random_step_%0d: light=%h idx=%0d pd=%b, want light=%h idx=%0d pd=%b",
                 i, light, active_idx, phase_done, exp_light(), m_active, m_pd);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_requester();
    test_max_green();
    test_min_green();
    test_round_robin();
    test_hold_and_async_reset();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
